// File: rtl/node_package.sv
// Shared RN/SN channel types: opcodes, request and data payloads.
package node_package;

   localparam int WORD_WIDTH = 32;
   localparam int ADDR_WIDTH = 16;

   typedef enum logic [1:0] {
      op_read      = 2'd0,
      op_write     = 2'd1,
      op_data_recv = 2'd2
   } opcode_t;

   typedef struct packed {
      opcode_t                 opcode;
      logic [ADDR_WIDTH-1:0]   addr;
   } ReqType;

   typedef struct packed {
      opcode_t                 opcode;
      logic [ADDR_WIDTH-1:0]   addr;
      logic [WORD_WIDTH-1:0]   data;
   } DataType;

endpackage

// File: rtl/rn_req_initiator_pkg.sv
// State encoding and response-check helper for the RN request initiator.
package rn_req_initiator_pkg;

   import node_package::*;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StPreReq   = 3'd1,
      StSendReq  = 3'd2,
      StWaitData = 3'd3,
      StGotPre   = 3'd4,
      StResp     = 3'd5
   } Type_rn_state;

   // A response is bad when it answers a different address or is not a data return.
   function automatic logic is_bad_response(input DataType rx, input ReqType req);
      return (rx.addr != req.addr) || (rx.opcode != op_data_recv);
   endfunction

endpackage

// File: rtl/rn_req_initiator.sv
// RN request initiator: one outstanding command, pre/valid request issue, SN data return.
// Optional response timeout is built when RN_TIMEOUT_EN is defined.
module rn_req_initiator
   import node_package::*;
   import rn_req_initiator_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    cmd_valid,
   output logic    cmd_ready,
   input  ReqType  cmd_req,
   output logic    pre_tx_req,
   output ReqType  tx_req,
   output logic    v_tx_req,
   input  logic    pre_rx_data,
   input  DataType rx_data,
   input  logic    v_rx_data,
   output logic    rsp_valid,
   input  logic    rsp_ready,
   output DataType rsp_data,
   output logic    rsp_error
);

   Type_rn_state r_state;
   Type_rn_state w_state_next;

   logic    r_cmd_ready;
   logic    r_pre_tx_req;
   logic    r_v_tx_req;
   logic    r_rsp_valid;
   logic    r_rsp_error;
   ReqType  r_tx_req;
   DataType r_rsp_data;

   ReqType  w_tx_req_next;
   DataType w_rsp_data_next;
   logic    w_rsp_error_next;
   logic    w_expire;

`ifdef RN_TIMEOUT_EN
   localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 w_waiting;

   assign w_waiting = (r_state == StWaitData) || (r_state == StGotPre);
   // Expiry is flagged on the cycle the counter is about to reach TIMEOUT_CYCLES.
   assign w_expire  = w_waiting && (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (r_state == StSendReq) begin
         r_cnt <= '0;
      end else if (w_waiting) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_expire = 1'b0;
`endif

   // NOTE: every signal driven here gets a default first so no path infers a latch.
   always_comb begin
      w_state_next     = r_state;
      w_tx_req_next    = r_tx_req;
      w_rsp_data_next  = r_rsp_data;
      w_rsp_error_next = r_rsp_error;

      unique case (r_state)
         StIdle: begin
            if (cmd_valid && r_cmd_ready) begin
               w_tx_req_next = cmd_req;
               w_state_next  = StPreReq;
            end
         end
         StPreReq: begin
            w_state_next = StSendReq;
         end
         StSendReq: begin
            // The SN may pre-announce combinationally off our valid pulse.
            w_state_next = pre_rx_data ? StGotPre : StWaitData;
         end
         StWaitData: begin
            if (w_expire) begin
               w_rsp_data_next  = '{opcode: op_data_recv, addr: r_tx_req.addr, data: '0};
               w_rsp_error_next = 1'b1;
               w_state_next     = StResp;
            end else if (pre_rx_data) begin
               w_state_next = StGotPre;
            end
         end
         StGotPre: begin
            // A real response in the expiry cycle takes precedence over the timeout.
            if (v_rx_data) begin
               w_rsp_data_next  = rx_data;
               w_rsp_error_next = is_bad_response(rx_data, r_tx_req);
               w_state_next     = StResp;
            end else if (w_expire) begin
               w_rsp_data_next  = '{opcode: op_data_recv, addr: r_tx_req.addr, data: '0};
               w_rsp_error_next = 1'b1;
               w_state_next     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // NOTE: state and registered outputs use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= StIdle;
         r_cmd_ready  <= 1'b1;
         r_pre_tx_req <= 1'b0;
         r_v_tx_req   <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_error  <= 1'b0;
         r_tx_req     <= '0;
         r_rsp_data   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_cmd_ready  <= (w_state_next == StIdle);
         r_pre_tx_req <= (w_state_next == StPreReq);
         r_v_tx_req   <= (w_state_next == StSendReq);
         r_rsp_valid  <= (w_state_next == StResp);
         r_rsp_error  <= w_rsp_error_next;
         r_tx_req     <= w_tx_req_next;
         r_rsp_data   <= w_rsp_data_next;
      end
   end

   assign cmd_ready  = r_cmd_ready;
   assign pre_tx_req = r_pre_tx_req;
   assign v_tx_req   = r_v_tx_req;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_error  = r_rsp_error;
   assign tx_req     = r_tx_req;
   assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_rn_req_initiator.sv
// Directed bench for rn_req_initiator; timeout cases build only with RN_TIMEOUT_EN.
module tb_rn_req_initiator;
   import node_package::*;

   logic    clk = 1'b0;
   logic    reset;
   logic    cmd_valid;
   logic    cmd_ready;
   ReqType  cmd_req;
   logic    pre_tx_req;
   ReqType  tx_req;
   logic    v_tx_req;
   logic    pre_rx_data;
   DataType rx_data;
   logic    v_rx_data;
   logic    rsp_valid;
   logic    rsp_ready;
   DataType rsp_data;
   logic    rsp_error;

   int n_checks = 0;
   int n_pass   = 0;

   rn_req_initiator #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_req     (cmd_req),
      .pre_tx_req  (pre_tx_req),
      .tx_req      (tx_req),
      .v_tx_req    (v_tx_req),
      .pre_rx_data (pre_rx_data),
      .rx_data     (rx_data),
      .v_rx_data   (v_rx_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_error   (rsp_error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic DataType mk_data(input opcode_t op, input logic [15:0] a, input logic [31:0] d);
      DataType x;
      x.opcode = op;
      x.addr   = a;
      x.data   = d;
      return x;
   endfunction

   // Cycle 0 handshake through cycle 2 (request valid); pre_rx_data is driven for cycle 2.
   task automatic issue(input opcode_t op, input logic [15:0] a, input logic pre_at_send);
      ReqType e;
      e.opcode = op;
      e.addr   = a;
      cmd_valid = 1'b1;
      cmd_req   = e;
      check("cmd_ready_c0", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      check("pre_tx_req_c1", pre_tx_req, 1);
      check("v_tx_req_c1", v_tx_req, 0);
      check("cmd_ready_c1", cmd_ready, 0);
      tick();
      check("v_tx_req_c2", v_tx_req, 1);
      check("pre_tx_req_c2", pre_tx_req, 0);
      check("tx_req_c2", tx_req, e);
      pre_rx_data = pre_at_send;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_after_hs", rsp_valid, 0);
      check("cmd_ready_after_hs", cmd_ready, 1);
   endtask

   initial begin
      DataType exp_d;
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_req     = '0;
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b0;
      rx_data     = '0;
      rsp_ready   = 1'b0;
      #2;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_pre_tx_req", pre_tx_req, 0);
      check("rst_v_tx_req", v_tx_req, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_error", rsp_error, 0);
      check("rst_tx_req", tx_req, 0);
      check("rst_rsp_data", rsp_data, 0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // Stray SN traffic and rsp_ready in IDLE are ignored.
      pre_rx_data = 1'b1;
      v_rx_data   = 1'b1;
      rsp_ready   = 1'b1;
      rx_data     = mk_data(op_data_recv, 16'h0001, 32'h1);
      tick();
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b0;
      rsp_ready   = 1'b0;
      check("idle_stray_rsp_valid", rsp_valid, 0);
      check("idle_stray_cmd_ready", cmd_ready, 1);
      tick();

      // Prompt read: pre at cycle 2, valid at cycle 3, response at cycle 4.
      issue(op_read, 16'h0003, 1'b1);
      tick();
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b1;
      rx_data     = mk_data(op_data_recv, 16'h0003, 32'h3);
      check("prompt_rsp_valid_c3", rsp_valid, 0);
      check("prompt_v_tx_req_c3", v_tx_req, 0);
      tick();
      v_rx_data = 1'b0;
      check("prompt_rsp_valid_c4", rsp_valid, 1);
      check("prompt_rsp_data", rsp_data.data, 32'h3);
      check("prompt_rsp_error", rsp_error, 0);
      check("prompt_pre_tx_req_c4", pre_tx_req, 0);
      check("prompt_v_tx_req_c4", v_tx_req, 0);
      release_rsp();

      // Delayed SN with a stray valid (no pre) in WAIT_DATA at cycle 4.
      issue(op_read, 16'h0010, 1'b0);
      for (int c = 3; c <= 6; c++) begin
         tick();
         pre_rx_data = 1'b0;
         v_rx_data   = (c == 4);
         rx_data     = mk_data(op_data_recv, 16'h0010, 32'hBAD);
         check("delay_cmd_ready", cmd_ready, 0);
         check("delay_rsp_valid", rsp_valid, 0);
      end
      tick();
      v_rx_data   = 1'b0;
      pre_rx_data = 1'b1;
      check("delay_rsp_valid_c7", rsp_valid, 0);
      tick();
      pre_rx_data = 1'b0;
      check("delay_cmd_ready_c8", cmd_ready, 0);
      tick();
      v_rx_data = 1'b1;
      rx_data   = mk_data(op_data_recv, 16'h0010, 32'hA5);
      check("delay_rsp_valid_c9", rsp_valid, 0);
      tick();
      v_rx_data = 1'b0;
      check("delay_rsp_valid_c10", rsp_valid, 1);
      check("delay_rsp_data", rsp_data.data, 32'hA5);
      check("delay_rsp_error", rsp_error, 0);
      check("delay_cmd_ready_c10", cmd_ready, 0);
      release_rsp();

      // Write with back-pressure; a second command held meanwhile and SN noise in RESP.
      issue(op_write, 16'h0021, 1'b1);
      tick();
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b1;
      exp_d       = mk_data(op_data_recv, 16'h0021, 32'hDEADBEEF);
      rx_data     = exp_d;
      tick();
      v_rx_data = 1'b0;
      cmd_valid = 1'b1;
      cmd_req   = '{opcode: op_read, addr: 16'h0005};
      for (int c = 0; c < 5; c++) begin
         pre_rx_data = 1'b1;
         v_rx_data   = 1'b1;
         rx_data     = mk_data(op_data_recv, 16'h0099, 32'h12345678);
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_data", rsp_data, exp_d);
         check("bp_rsp_error", rsp_error, 0);
         check("bp_cmd_ready", cmd_ready, 0);
         check("bp_pre_tx_req", pre_tx_req, 0);
         tick();
      end
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b0;
      check("bp_rsp_stable_end", rsp_data, exp_d);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_rsp_valid_drop", rsp_valid, 0);
      check("bp_pre_not_yet", pre_tx_req, 0);

      // Held command now accepted; SN answers with the wrong address.
      issue(op_read, 16'h0005, 1'b1);
      tick();
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b1;
      rx_data     = mk_data(op_data_recv, 16'h0006, 32'h77);
      tick();
      v_rx_data = 1'b0;
      check("mm_addr_rsp_valid", rsp_valid, 1);
      check("mm_addr_rsp_error", rsp_error, 1);
      check("mm_addr_rsp_addr", rsp_data.addr, 16'h0006);
      release_rsp();

      // Right address but the opcode is not a data return.
      issue(op_read, 16'h0009, 1'b1);
      tick();
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b1;
      rx_data     = mk_data(op_read, 16'h0009, 32'h1);
      tick();
      v_rx_data = 1'b0;
      check("mm_op_rsp_valid", rsp_valid, 1);
      check("mm_op_rsp_error", rsp_error, 1);
      release_rsp();

      // Reset while in GOT_PRE drops the transaction, including a valid in that cycle.
      issue(op_read, 16'h0030, 1'b1);
      tick();
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b1;
      rx_data     = mk_data(op_data_recv, 16'h0030, 32'h30);
      reset       = 1'b1;
      #1;
      check("mid_rst_cmd_ready_async", cmd_ready, 1);
      tick();
      reset     = 1'b0;
      v_rx_data = 1'b0;
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      tick();
      check("mid_rst_rsp_valid_later", rsp_valid, 0);
      issue(op_read, 16'h0031, 1'b1);
      tick();
      pre_rx_data = 1'b0;
      v_rx_data   = 1'b1;
      rx_data     = mk_data(op_data_recv, 16'h0031, 32'h1234);
      tick();
      v_rx_data = 1'b0;
      check("post_rst_rsp_valid", rsp_valid, 1);
      check("post_rst_rsp_data", rsp_data.data, 32'h1234);
      check("post_rst_rsp_error", rsp_error, 0);
      release_rsp();

`ifdef RN_TIMEOUT_EN
      // Silent SN: WAIT_DATA entered at cycle 3, timeout response at cycle 11.
      issue(op_read, 16'h0040, 1'b0);
      for (int c = 3; c <= 10; c++) begin
         tick();
         pre_rx_data = 1'b0;
         check("to_rsp_valid_wait", rsp_valid, 0);
      end
      tick();
      check("to_rsp_valid", rsp_valid, 1);
      check("to_rsp_error", rsp_error, 1);
      check("to_rsp_data", rsp_data, mk_data(op_data_recv, 16'h0040, 32'h0));
      release_rsp();

      // Valid arriving in the expiry cycle (cycle 10) wins over the timeout.
      issue(op_read, 16'h0041, 1'b0);
      for (int c = 3; c <= 10; c++) begin
         tick();
         pre_rx_data = (c == 3);
         v_rx_data   = (c == 10);
         rx_data     = mk_data(op_data_recv, 16'h0041, 32'h5A);
         check("to_race_rsp_valid_wait", rsp_valid, 0);
      end
      tick();
      v_rx_data = 1'b0;
      check("to_race_rsp_valid", rsp_valid, 1);
      check("to_race_rsp_error", rsp_error, 0);
      check("to_race_rsp_data", rsp_data.data, 32'h5A);
      release_rsp();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rn_req_initiator.md
Name: rn_req_initiator

Overview:
- Request-node initiator on the RN↔SN request/data channel pair: takes one command from the local core, issues it on the request channel using the pre/valid handshake, waits for the SN data response and returns it to the core.
- One transaction outstanding at a time; sits between the core-side command port and an sn responder.

Parameters:
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT_DATA/GOT_PRE before the timeout response (used only with RN_TIMEOUT_EN).
- CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  core command present
- cmd_ready  out  1  block can accept a command
- cmd_req  in  ReqType  opcode (op_read/op_write) + addr
- pre_tx_req  out  1  request pre-announce pulse
- tx_req  out  ReqType  request payload
- v_tx_req  out  1  request valid pulse
- pre_rx_data  in  1  data pre-announce from SN
- rx_data  in  DataType  response payload (opcode, addr, data)
- v_rx_data  in  1  response valid from SN
- rsp_valid  out  1  response to core valid
- rsp_ready  in  1  core accepts response
- rsp_data  out  DataType  captured response
- rsp_error  out  1  timeout / address-mismatch flag

Behaviour:
- Reset (asynchronous, any state): state=IDLE; outputs cmd_ready=1, pre_tx_req=0, v_tx_req=0, rsp_valid=0, rsp_error=0, tx_req='0, rsp_data='0; timeout counter=0. A transaction in flight at reset is dropped.
- All outputs are registered.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_req into tx_req → PRE_REQ.
  - PRE_REQ: pre_tx_req=1 for exactly one cycle → SEND_REQ.
  - SEND_REQ: v_tx_req=1 for exactly one cycle; tx_req stable. If pre_rx_data is high this same cycle (SN pre-announces combinationally on v_rx_req) → GOT_PRE, else → WAIT_DATA.
  - WAIT_DATA: on pre_rx_data → GOT_PRE. v_rx_data without a preceding pre is ignored.
  - GOT_PRE: on v_rx_data, capture rx_data into rsp_data → RESP. rsp_error=1 if rx_data.addr != tx_req.addr or rx_data.opcode != op_data_recv. pre_rx_data seen again here is ignored.
  - RESP: rsp_valid held until rsp_ready → IDLE. rsp_data and rsp_error stay stable while rsp_valid=1.
- cmd_ready=0 in every state except IDLE. cmd_valid outside IDLE is not consumed.
- Latency from command handshake at cycle 0:
  - pre_tx_req at cycle 1, v_tx_req at cycle 2.
  - Earliest rsp_valid at cycle 4: SN pre at cycle 2, v_rx_data at cycle 3.
- Writes are completed the same way: the SN response is returned to the core, and rsp_data.data is passed through unchecked.
- pre_rx_data or v_rx_data arriving in IDLE, PRE_REQ or RESP is ignored.
- rsp_ready high while rsp_valid=0 has no effect. rsp_valid&&rsp_ready → IDLE with cmd_ready=1 next cycle. No same-cycle command acceptance while in RESP.

Optional Feature:
- Macro RN_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT_DATA and increments each cycle in WAIT_DATA/GOT_PRE.
  - When it reaches TIMEOUT_CYCLES without v_rx_data → RESP with rsp_error=1, rsp_data.addr=tx_req.addr, rsp_data.opcode=op_data_recv, rsp_data.data='0.
  - v_rx_data in the same cycle as expiry wins: normal capture.
- Undefined: no counter; the block waits indefinitely; rsp_error only reflects mismatch.

Decomposition:
- node_package holds ReqType, DataType, opcode enum (op_read, op_write, op_data_recv), WORD_WIDTH and ADDR_WIDTH.
- New package enum Type_rn_state {StIdle, StPreReq, StSendReq, StWaitData, StGotPre, StResp}.
- Single module; no sub-module needed. The timeout counter is inline under the macro.

Test Plan:
- Read, prompt SN: cmd op_read addr=3, SN pre at cycle 2, v at cycle 3 with data=3, addr=3 → rsp_valid at cycle 4, rsp_data.data=3, rsp_error=0; pre_tx_req only at cycle 1, v_tx_req only at cycle 2.
- Delayed SN: pre_rx_data at cycle 7, v_rx_data at cycle 9, data=0xA5 → rsp_valid at cycle 10, data=0xA5; cmd_ready=0 throughout cycles 1-10.
- Back-pressure and stray inputs: rsp_ready low 5 cycles → rsp_valid and rsp_data stable; a second cmd_valid held is accepted only after the response handshake. Stray v_rx_data in WAIT_DATA without pre → ignored, no rsp_valid.
- Mismatch: request addr=5, response addr=6 → rsp_valid with rsp_error=1, rsp_data.addr=6.
- Reset mid-transaction: assert reset in GOT_PRE → next cycle IDLE, cmd_ready=1, rsp_valid=0; a subsequent read completes normally.
- RN_TIMEOUT_EN, TIMEOUT_CYCLES=8: no SN response → rsp_valid=1 with rsp_error=1, data=0, 8 cycles after WAIT_DATA entry. v_rx_data at the expiry cycle → normal response, rsp_error=0.
